// File: rtl/reservation_station.sv
// reservation_station: holding buffer between the decoder and the ALU.
// An issued instruction waits here until both source operands are resolved.
// Operands are resolved directly from the issue or from ALU/LSB result
// broadcasts. Each cycle the lowest-index ready entry is sent out through a
// registered ALU port. Slot selection and ready checks use only registered
// state, so a slot freed or woken this cycle takes effect from the next cycle.
module reservation_station #(
   parameter int RS_SIZE = 16,
   parameter int ROB_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             rollback,
   input  logic             rs_en,
   input  logic [ROB_W-1:0] rob_pos,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7,
   input  logic             rs1_rdy,
   input  logic [31:0]      rs1_val,
   input  logic [ROB_W-1:0] rs1_rob_pos,
   input  logic             rs2_rdy,
   input  logic [31:0]      rs2_val,
   input  logic [ROB_W-1:0] rs2_rob_pos,
   input  logic [31:0]      imm,
   input  logic [31:0]      pc,
   output logic             rs_full,
   input  logic             alu_done,
   input  logic [31:0]      alu_res,
   input  logic [ROB_W-1:0] alu_res_rob_pos,
   input  logic             lsb_done,
   input  logic [31:0]      lsb_res,
   input  logic [ROB_W-1:0] lsb_res_rob_pos,
   output logic             alu_en,
   output logic [6:0]       alu_opcode,
   output logic [2:0]       alu_funct3,
   output logic             alu_funct7,
   output logic [31:0]      alu_val1,
   output logic [31:0]      alu_val2,
   output logic [31:0]      alu_imm,
   output logic [31:0]      alu_pc,
   output logic [ROB_W-1:0] alu_rob_pos
);

   localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
   localparam int CW = IW + 1;

   typedef struct packed {
      logic [6:0]       opcode;
      logic [2:0]       funct3;
      logic             funct7;
      logic             q1_rdy;
      logic [31:0]      v1;
      logic [ROB_W-1:0] t1;
      logic             q2_rdy;
      logic [31:0]      v2;
      logic [ROB_W-1:0] t2;
      logic [31:0]      imm;
      logic [31:0]      pc;
      logic [ROB_W-1:0] rob;
   } entry_t;

   logic [RS_SIZE-1:0] busy_q;
   logic [RS_SIZE-1:0] busy_d;
   entry_t             ent_q [RS_SIZE];
   entry_t             ent_d [RS_SIZE];
   entry_t             new_ent;

   logic               free_found;
   logic [IW-1:0]      free_idx;
   logic               disp_found;
   logic [IW-1:0]      disp_idx;
   logic [CW-1:0]      busy_cnt;

   logic               alu_en_q,     alu_en_d;
   logic [6:0]         alu_opcode_q, alu_opcode_d;
   logic [2:0]         alu_funct3_q, alu_funct3_d;
   logic               alu_funct7_q, alu_funct7_d;
   logic [31:0]        alu_val1_q,   alu_val1_d;
   logic [31:0]        alu_val2_q,   alu_val2_d;
   logic [31:0]        alu_imm_q,    alu_imm_d;
   logic [31:0]        alu_pc_q,     alu_pc_d;
   logic [ROB_W-1:0]   alu_rob_q,    alu_rob_d;

   // Resolve one operand against this cycle's broadcasts; the ALU result wins
   // if both buses carry the same tag. Returns {ready, value}.
   function automatic logic [32:0] snoop(input logic        ok,
                                         input logic [31:0] val,
                                         input logic [ROB_W-1:0] tag);
      logic [32:0] r;
      r = {ok, val};
      if (!ok) begin
         if (alu_done && (tag == alu_res_rob_pos)) begin
            r = {1'b1, alu_res};
         end else if (lsb_done && (tag == lsb_res_rob_pos)) begin
            r = {1'b1, lsb_res};
         end
      end
      return r;
   endfunction

   // Lowest free slot, lowest ready slot and occupancy, all from registered state.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      disp_found = 1'b0;
      disp_idx   = '0;
      busy_cnt   = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         busy_cnt = busy_cnt + CW'(busy_q[i]);
         if (!free_found && !busy_q[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
         if (!disp_found && busy_q[i] && ent_q[i].q1_rdy && ent_q[i].q2_rdy) begin
            disp_found = 1'b1;
            disp_idx   = IW'(i);
         end
      end
   end

   // One slot of slack covers an issue that is already on its way.
   assign rs_full = (busy_cnt >= CW'(RS_SIZE - 1));

   // Incoming instruction, with operands snooped from same-cycle broadcasts.
   always_comb begin
      new_ent                 = '0;
      new_ent.opcode          = opcode;
      new_ent.funct3          = funct3;
      new_ent.funct7          = funct7;
      {new_ent.q1_rdy, new_ent.v1} = snoop(rs1_rdy, rs1_val, rs1_rob_pos);
      new_ent.t1              = rs1_rob_pos;
      {new_ent.q2_rdy, new_ent.v2} = snoop(rs2_rdy, rs2_val, rs2_rob_pos);
      new_ent.t2              = rs2_rob_pos;
      new_ent.imm             = imm;
      new_ent.pc              = pc;
      new_ent.rob             = rob_pos;
   end

   // Entry next state: wakeup of waiting operands, issue into the free slot,
   // and release of the slot being dispatched.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < RS_SIZE; i++) begin
         ent_d[i] = ent_q[i];
         if (busy_q[i]) begin
            {ent_d[i].q1_rdy, ent_d[i].v1} = snoop(ent_q[i].q1_rdy, ent_q[i].v1, ent_q[i].t1);
            {ent_d[i].q2_rdy, ent_d[i].v2} = snoop(ent_q[i].q2_rdy, ent_q[i].v2, ent_q[i].t2);
         end
      end
      // An issue into a full station has nowhere to go and is dropped.
      if (rs_en && free_found) begin
         ent_d[free_idx]  = new_ent;
         busy_d[free_idx] = 1'b1;
      end
      if (disp_found) begin
         busy_d[disp_idx] = 1'b0;
      end
   end

   // Dispatch register contents; data holds when nothing is dispatched.
   always_comb begin
      alu_en_d     = disp_found;
      alu_opcode_d = alu_opcode_q;
      alu_funct3_d = alu_funct3_q;
      alu_funct7_d = alu_funct7_q;
      alu_val1_d   = alu_val1_q;
      alu_val2_d   = alu_val2_q;
      alu_imm_d    = alu_imm_q;
      alu_pc_d     = alu_pc_q;
      alu_rob_d    = alu_rob_q;
      if (disp_found) begin
         alu_opcode_d = ent_q[disp_idx].opcode;
         alu_funct3_d = ent_q[disp_idx].funct3;
         alu_funct7_d = ent_q[disp_idx].funct7;
         alu_val1_d   = ent_q[disp_idx].v1;
         alu_val2_d   = ent_q[disp_idx].v2;
         alu_imm_d    = ent_q[disp_idx].imm;
         alu_pc_d     = ent_q[disp_idx].pc;
         alu_rob_d    = ent_q[disp_idx].rob;
      end
   end

   // State update: reset, then flush, then stall, then normal advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q       <= '0;
         alu_en_q     <= 1'b0;
         alu_opcode_q <= '0;
         alu_funct3_q <= '0;
         alu_funct7_q <= 1'b0;
         alu_val1_q   <= '0;
         alu_val2_q   <= '0;
         alu_imm_q    <= '0;
         alu_pc_q     <= '0;
         alu_rob_q    <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            ent_q[i] <= '0;
         end
      end else if (rollback) begin
         // Stale dispatch data is harmless once alu_en is low.
         busy_q   <= '0;
         alu_en_q <= 1'b0;
      end else if (rdy) begin
         busy_q       <= busy_d;
         alu_en_q     <= alu_en_d;
         alu_opcode_q <= alu_opcode_d;
         alu_funct3_q <= alu_funct3_d;
         alu_funct7_q <= alu_funct7_d;
         alu_val1_q   <= alu_val1_d;
         alu_val2_q   <= alu_val2_d;
         alu_imm_q    <= alu_imm_d;
         alu_pc_q     <= alu_pc_d;
         alu_rob_q    <= alu_rob_d;
         for (int i = 0; i < RS_SIZE; i++) begin
            ent_q[i] <= ent_d[i];
         end
      end
   end

   assign alu_en      = alu_en_q;
   assign alu_opcode  = alu_opcode_q;
   assign alu_funct3  = alu_funct3_q;
   assign alu_funct7  = alu_funct7_q;
   assign alu_val1    = alu_val1_q;
   assign alu_val2    = alu_val2_q;
   assign alu_imm     = alu_imm_q;
   assign alu_pc      = alu_pc_q;
   assign alu_rob_pos = alu_rob_q;

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed table, multi-cycle corner sequences and a
// randomized run against a slot-array reference model.
module tb_reservation_station;
   localparam int N = 16;
   localparam logic [6:0] ADDI = 7'b0010011;
   localparam logic [6:0] ADD  = 7'b0110011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rdy, rollback, rs_en;
   logic [3:0]  rob_pos;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7;
   logic        rs1_rdy, rs2_rdy;
   logic [31:0] rs1_val, rs2_val;
   logic [3:0]  rs1_rob_pos, rs2_rob_pos;
   logic [31:0] imm, pc;
   logic        rs_full;
   logic        alu_done, lsb_done;
   logic [31:0] alu_res, lsb_res;
   logic [3:0]  alu_res_rob_pos, lsb_res_rob_pos;
   logic        alu_en;
   logic [6:0]  alu_opcode;
   logic [2:0]  alu_funct3;
   logic        alu_funct7;
   logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
   logic [3:0]  alu_rob_pos;

   reservation_station #(.RS_SIZE(N), .ROB_W(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rs_en(rs_en),
      .rob_pos(rob_pos), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rs1_rdy(rs1_rdy), .rs1_val(rs1_val), .rs1_rob_pos(rs1_rob_pos),
      .rs2_rdy(rs2_rdy), .rs2_val(rs2_val), .rs2_rob_pos(rs2_rob_pos),
      .imm(imm), .pc(pc), .rs_full(rs_full),
      .alu_done(alu_done), .alu_res(alu_res), .alu_res_rob_pos(alu_res_rob_pos),
      .lsb_done(lsb_done), .lsb_res(lsb_res), .lsb_res_rob_pos(lsb_res_rob_pos),
      .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
      .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
      .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic idle();
      rst = 0; rdy = 1; rollback = 0; rs_en = 0;
      rob_pos = 0; opcode = 0; funct3 = 0; funct7 = 0;
      rs1_rdy = 0; rs1_val = 0; rs1_rob_pos = 0;
      rs2_rdy = 0; rs2_val = 0; rs2_rob_pos = 0;
      imm = 0; pc = 0;
      alu_done = 0; alu_res = 0; alu_res_rob_pos = 0;
      lsb_done = 0; lsb_res = 0; lsb_res_rob_pos = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [3:0] rob, input logic [6:0] op,
                      input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                      input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                      input logic [31:0] im);
      rs_en = 1; rob_pos = rob; opcode = op;
      rs1_rdy = r1; rs1_val = v1; rs1_rob_pos = t1;
      rs2_rdy = r2; rs2_val = v2; rs2_rob_pos = t2;
      imm = im; pc = 32'h1000;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        is_rst, en;
      logic [3:0]  rob;
      logic [6:0]  op;
      logic        r1;  logic [31:0] v1; logic [3:0] t1;
      logic        r2;  logic [31:0] v2; logic [3:0] t2;
      logic [31:0] im;
      logic        ad;  logic [3:0]  at; logic [31:0] av;
      logic        ld;  logic [3:0]  lt; logic [31:0] lv;
      logic        e_en, e_dat;
      logic [31:0] e_v1, e_v2;
      logic [3:0]  e_rob;
      logic [31:0] e_imm;
   } vec_t;

   function automatic vec_t mk(logic is_rst, logic en, logic [3:0] rob, logic [6:0] op,
                               logic r1, logic [31:0] v1, logic [3:0] t1,
                               logic r2, logic [31:0] v2, logic [3:0] t2, logic [31:0] im,
                               logic ad, logic [3:0] at, logic [31:0] av,
                               logic ld, logic [3:0] lt, logic [31:0] lv,
                               logic e_en, logic e_dat, logic [31:0] e_v1,
                               logic [31:0] e_v2, logic [3:0] e_rob, logic [31:0] e_imm);
      vec_t v;
      v.is_rst = is_rst; v.en = en; v.rob = rob; v.op = op;
      v.r1 = r1; v.v1 = v1; v.t1 = t1; v.r2 = r2; v.v2 = v2; v.t2 = t2; v.im = im;
      v.ad = ad; v.at = at; v.av = av; v.ld = ld; v.lt = lt; v.lv = lv;
      v.e_en = e_en; v.e_dat = e_dat; v.e_v1 = e_v1; v.e_v2 = e_v2;
      v.e_rob = e_rob; v.e_imm = e_imm;
      return v;
   endfunction

   vec_t tv[$];

   // ---------------- reference model ----------------
   typedef struct {
      logic [3:0]  rob;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic        r1; logic [31:0] v1; logic [3:0] t1;
      logic        r2; logic [31:0] v2; logic [3:0] t2;
      logic [31:0] imm, pc;
   } ment_t;

   ment_t mslot[N];
   bit    mbusy[N];
   bit    exp_en;
   ment_t eo;

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(mbusy[i]);
      return c;
   endfunction

   function automatic ment_t wake(ment_t e);
      ment_t r = e;
      if (!r.r1 && alu_done && r.t1 == alu_res_rob_pos) begin r.r1 = 1; r.v1 = alu_res; end
      else if (!r.r1 && lsb_done && r.t1 == lsb_res_rob_pos) begin r.r1 = 1; r.v1 = lsb_res; end
      if (!r.r2 && alu_done && r.t2 == alu_res_rob_pos) begin r.r2 = 1; r.v2 = alu_res; end
      else if (!r.r2 && lsb_done && r.t2 == lsb_res_rob_pos) begin r.r2 = 1; r.v2 = lsb_res; end
      return r;
   endfunction

   task automatic model_step();
      int    pick, hole;
      ment_t inc, sel;
      if (rollback) begin
         for (int i = 0; i < N; i++) mbusy[i] = 0;
         exp_en = 0;
         return;
      end
      if (!rdy) return;
      pick = -1; hole = -1;
      for (int i = 0; i < N; i++) begin
         if (hole < 0 && !mbusy[i]) hole = i;
         if (pick < 0 && mbusy[i] && mslot[i].r1 && mslot[i].r2) pick = i;
      end
      if (pick >= 0) sel = mslot[pick];
      for (int i = 0; i < N; i++) if (mbusy[i]) mslot[i] = wake(mslot[i]);
      if (rs_en && hole >= 0) begin
         inc.rob = rob_pos; inc.op = opcode; inc.f3 = funct3; inc.f7 = funct7;
         inc.r1 = rs1_rdy; inc.v1 = rs1_val; inc.t1 = rs1_rob_pos;
         inc.r2 = rs2_rdy; inc.v2 = rs2_val; inc.t2 = rs2_rob_pos;
         inc.imm = imm; inc.pc = pc;
         mslot[hole] = wake(inc);
         mbusy[hole] = 1;
      end
      if (pick >= 0) begin
         exp_en = 1;
         eo = sel;
         mbusy[pick] = 0;
      end else begin
         exp_en = 0;
      end
   endtask

   initial begin
      idle();

      // ---------- table: basic issue/dispatch and same-cycle snooping ----------
      tv.push_back(mk(1,0,0,0,   0,0,0, 0,0,0, 0,      0,0,0,      0,0,0,     0,1,0,0,0,0));
      tv.push_back(mk(0,1,3,ADDI,1,5,0, 1,0,0, 7,      0,0,0,      0,0,0,     0,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,   0,0,0, 0,0,0, 0,      0,0,0,      0,0,0,     1,1,5,0,3,7));
      tv.push_back(mk(0,0,0,0,   0,0,0, 0,0,0, 0,      0,0,0,      0,0,0,     0,0,0,0,0,0));
      tv.push_back(mk(0,1,2,ADD, 0,0,1, 1,4,0, 0,      0,0,0,      0,0,0,     0,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,   0,0,0, 0,0,0, 0,      0,0,0,      0,0,0,     0,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,   0,0,0, 0,0,0, 0,      1,1,10,     0,0,0,     0,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,   0,0,0, 0,0,0, 0,      0,0,0,      0,0,0,     1,1,10,4,2,0));
      tv.push_back(mk(0,0,0,0,   0,0,0, 0,0,0, 0,      0,0,0,      0,0,0,     0,0,0,0,0,0));
      tv.push_back(mk(0,1,5,ADD, 0,0,9, 1,3,0, 0,      1,9,'h1234, 0,0,0,     0,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,   0,0,0, 0,0,0, 0,      0,0,0,      0,0,0,     1,1,'h1234,3,5,0));
      tv.push_back(mk(0,1,7,ADDI,1,1,0, 0,0,6, 'h20,   0,0,0,      1,6,'h55,  0,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,   0,0,0, 0,0,0, 0,      0,0,0,      0,0,0,     1,1,1,'h55,7,'h20));
      tv.push_back(mk(0,1,8,ADD, 0,0,4, 1,2,0, 0,      1,5,'hAA,   0,0,0,     0,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,   0,0,0, 0,0,0, 0,      0,0,0,      0,0,0,     0,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,   0,0,0, 0,0,0, 0,      0,0,0,      1,4,'h99,  0,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,   0,0,0, 0,0,0, 0,      0,0,0,      0,0,0,     1,1,'h99,2,8,0));
      tv.push_back(mk(0,0,0,0,   0,0,0, 0,0,0, 0,      0,0,0,      0,0,0,     0,0,0,0,0,0));

      for (int r = 0; r < tv.size(); r++) begin
         idle();
         rst = tv[r].is_rst;
         if (tv[r].en) put(tv[r].rob, tv[r].op, tv[r].r1, tv[r].v1, tv[r].t1,
                           tv[r].r2, tv[r].v2, tv[r].t2, tv[r].im);
         alu_done = tv[r].ad; alu_res_rob_pos = tv[r].at; alu_res = tv[r].av;
         lsb_done = tv[r].ld; lsb_res_rob_pos = tv[r].lt; lsb_res = tv[r].lv;
         step();
         chk($sformatf("tbl%0d_en", r), alu_en, tv[r].e_en);
         chk($sformatf("tbl%0d_full", r), rs_full, 0);
         if (tv[r].e_dat) begin
            chk($sformatf("tbl%0d_val1", r), alu_val1, tv[r].e_v1);
            chk($sformatf("tbl%0d_val2", r), alu_val2, tv[r].e_v2);
            chk($sformatf("tbl%0d_rob", r), alu_rob_pos, tv[r].e_rob);
            chk($sformatf("tbl%0d_imm", r), alu_imm, tv[r].e_imm);
         end
      end

      // ---------- younger ready entry overtakes an older waiting one ----------
      idle(); put(10, ADD, 0, 0, 6, 1, 1, 0, 0); step(); chk("ord_en0", alu_en, 0);
      idle(); put(11, ADD, 1, 2, 0, 1, 3, 0, 0); step(); chk("ord_en1", alu_en, 0);
      idle(); step(); chk("ord_first_en", alu_en, 1); chk("ord_first_rob", alu_rob_pos, 11);
      idle(); lsb_done = 1; lsb_res_rob_pos = 6; lsb_res = 32'hFF; step();
      chk("ord_wake_en", alu_en, 0);
      idle(); step(); chk("ord_second_en", alu_en, 1); chk("ord_second_rob", alu_rob_pos, 10);
      chk("ord_second_val1", alu_val1, 32'hFF);
      idle(); step(); chk("ord_drain_en", alu_en, 0);

      // ---------- fill, overflow drop, mass wakeup ----------
      for (int k = 0; k < 16; k++) begin
         idle(); put(4'(k), ADD, 0, 0, 12, 1, 32'(k), 0, 0); step();
         chk($sformatf("fill%0d_full", k), rs_full, (k + 1 >= 15));
         chk($sformatf("fill%0d_en", k), alu_en, 0);
      end
      idle(); put(13, ADDI, 1, 32'hDEAD, 0, 1, 0, 0, 0); step();
      chk("drop_en", alu_en, 0); chk("drop_full", rs_full, 1);
      idle(); alu_done = 1; alu_res_rob_pos = 12; alu_res = 32'h77; step();
      chk("mass_wake_en", alu_en, 0); chk("mass_wake_full", rs_full, 1);
      for (int k = 0; k < 16; k++) begin
         idle(); step();
         chk($sformatf("mass%0d_en", k), alu_en, 1);
         chk($sformatf("mass%0d_rob", k), alu_rob_pos, k);
         chk($sformatf("mass%0d_val1", k), alu_val1, 32'h77);
         chk($sformatf("mass%0d_val2", k), alu_val2, k);
         chk($sformatf("mass%0d_full", k), rs_full, (16 - k - 1 >= 15));
      end
      idle(); step(); chk("mass_done_en", alu_en, 0); chk("mass_done_full", rs_full, 0);

      // ---------- stall: rdy low holds everything and ignores broadcasts ----------
      idle(); put(4, ADD, 0, 0, 3, 1, 0, 0, 0); step(); chk("stall_iss0_en", alu_en, 0);
      idle(); put(9, ADD, 1, 32'h11, 0, 1, 32'h22, 0, 0); step(); chk("stall_iss1_en", alu_en, 0);
      for (int k = 0; k < 3; k++) begin
         idle(); rdy = 0; alu_done = 1; alu_res_rob_pos = 3; alu_res = 32'h33; step();
         chk($sformatf("stall%0d_en", k), alu_en, 0);
      end
      idle(); step(); chk("resume_en", alu_en, 1); chk("resume_rob", alu_rob_pos, 9);
      chk("resume_val1", alu_val1, 32'h11);
      idle(); step(); chk("stall_ignored_en0", alu_en, 0);
      idle(); step(); chk("stall_ignored_en1", alu_en, 0);

      // ---------- rollback with concurrent issue and broadcast ----------
      for (int k = 0; k < 4; k++) begin
         idle(); put(4'(10 + k), ADD, 0, 0, 2, 1, 0, 0, 0); step();
         chk($sformatf("rb_fill%0d_en", k), alu_en, 0);
      end
      idle(); rollback = 1; put(14, ADDI, 1, 5, 0, 1, 6, 0, 0);
      alu_done = 1; alu_res_rob_pos = 3; alu_res = 32'h44; step();
      chk("rb_en", alu_en, 0); chk("rb_full", rs_full, 0);
      idle(); alu_done = 1; alu_res_rob_pos = 2; alu_res = 32'h45;
      lsb_done = 1; lsb_res_rob_pos = 3; lsb_res = 32'h46; step();
      chk("rb_after_bcast_en", alu_en, 0);
      for (int k = 0; k < 3; k++) begin
         idle(); step(); chk($sformatf("rb_quiet%0d_en", k), alu_en, 0);
      end
      for (int k = 0; k < 14; k++) begin
         idle(); put(4'(k), ADD, 0, 0, 15, 1, 0, 0, 0); step();
      end
      chk("rb_refill_full", rs_full, 0);
      idle(); put(6, ADDI, 1, 32'h66, 0, 1, 0, 0, 0); step();
      chk("rb_refill15_full", rs_full, 1);
      idle(); step(); chk("rb_post_en", alu_en, 1); chk("rb_post_rob", alu_rob_pos, 6);
      chk("rb_post_val1", alu_val1, 32'h66); chk("rb_post_full", rs_full, 0);

      // ---------- randomized run against the model ----------
      idle(); rst = 1; step();
      for (int i = 0; i < N; i++) mbusy[i] = 0;
      exp_en = 0;
      for (int c = 0; c < 3000; c++) begin
         idle();
         rdy      = ($urandom_range(99) < 88);
         rollback = ($urandom_range(199) == 0);
         if ($urandom_range(99) < 55) begin
            rs_en = 1; rob_pos = 4'($urandom); opcode = 7'($urandom);
            funct3 = 3'($urandom); funct7 = 1'($urandom);
            rs1_rdy = 1'($urandom_range(1)); rs1_val = $urandom; rs1_rob_pos = 4'($urandom_range(7));
            rs2_rdy = 1'($urandom_range(1)); rs2_val = $urandom; rs2_rob_pos = 4'($urandom_range(7));
            imm = $urandom; pc = $urandom;
         end
         if ($urandom_range(99) < 35) begin
            alu_done = 1; alu_res_rob_pos = 4'($urandom_range(7)); alu_res = $urandom;
         end
         if ($urandom_range(99) < 30) begin
            lsb_done = 1; lsb_res_rob_pos = 4'($urandom_range(7)); lsb_res = $urandom;
            if (alu_done && lsb_res_rob_pos == alu_res_rob_pos) lsb_res_rob_pos ^= 4'h1;
         end
         model_step();
         step();
         chk("rnd_en", alu_en, exp_en);
         chk("rnd_full", rs_full, (m_count() >= N - 1));
         if (exp_en) begin
            chk("rnd_rob", alu_rob_pos, eo.rob);
            chk("rnd_val1", alu_val1, eo.v1);
            chk("rnd_val2", alu_val2, eo.v2);
            chk("rnd_imm", alu_imm, eo.imm);
            chk("rnd_pc", alu_pc, eo.pc);
            chk("rnd_op", {alu_opcode, alu_funct3, alu_funct7}, {eo.op, eo.f3, eo.f7});
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
